// File: rtl/uart_packet_receiver.sv
`default_nettype none
// ============================================================================
//  uart_packet_receiver : 8E1-style UART frame receiver (start, 8 data, even
//  parity, stop). Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
//  Revision: 1.0
// ============================================================================
module uart_packet_receiver #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic [10:0] packet_out,
    output logic        data_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t          state;
    state_t          nextState;
    logic            rxMeta;
    logic            rxS;
    logic            rxP;
    logic [TW-1:0]   timer;
    logic [2:0]      bitCnt;
    logic [7:0]      shiftReg;
    logic            parityBit;
    logic            startEdge;
    logic            sampleTick;
    logic            decideTick;
    logic            bitVal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
            rxP    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxS    <= rxMeta;
            rxP    <= rxS;
        end
    end

    assign startEdge  = (state == IDLE) && rxP && !rxS;
    assign sampleTick = ((state == START) && (timer == HALF_LAST)) ||
                        (((state == DATA) || (state == PARITY) || (state == STOP)) &&
                         (timer == FULL_LAST));

`ifdef UART_RX_MAJORITY_EN
    // One cycle after the sample point rxS/rxP/rxPP hold the +1/0/-1 samples.
    logic rxPP;
    logic tickDly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxPP    <= 1'b1;
            tickDly <= 1'b0;
        end else begin
            rxPP    <= rxP;
            tickDly <= sampleTick;
        end
    end

    assign decideTick = tickDly;
    assign bitVal     = (rxS & rxP) | (rxS & rxPP) | (rxP & rxPP);
`else
    assign decideTick = sampleTick;
    assign bitVal     = rxS;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:      if (startEdge) nextState = START;
            START:     if (decideTick) nextState = bitVal ? IDLE : DATA;
            DATA:      if (decideTick && (bitCnt == 3'd7)) nextState = PARITY;
            PARITY:    if (decideTick) nextState = STOP;
            STOP:      if (decideTick) nextState = bitVal ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rxS) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // The detection cycle counts as timer 0, so START is entered with timer 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((state == IDLE) || (state == WAIT_IDLE)) begin
            timer <= {{(TW-1){1'b0}}, startEdge};
        end else if (sampleTick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitCnt     <= 3'd0;
            shiftReg   <= 8'd0;
            parityBit  <= 1'b0;
            data_out   <= 8'd0;
            packet_out <= 11'd0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (state == IDLE) begin
                bitCnt <= 3'd0;
            end
            if (decideTick) begin
                case (state)
                    DATA: begin
                        shiftReg[bitCnt] <= bitVal;
                        bitCnt           <= bitCnt + 3'd1;
                    end
                    PARITY: parityBit <= bitVal;
                    STOP: begin
                        // Bit 0 flags a validated start bit for the presented frame.
                        data_valid <= 1'b1;
                        data_out   <= shiftReg;
                        packet_out <= {bitVal, parityBit, shiftReg, 1'b1};
                        parity_err <= parityBit ^ (^shiftReg);
                        frame_err  <= ~bitVal;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_uart_packet_receiver : directed frames against a frame-level model.
//  Revision: 1.0
// ============================================================================
module tb_uart_packet_receiver;

    localparam int CPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  data_out;
    logic [10:0] packet_out;
    logic        data_valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    uart_packet_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .packet_out (packet_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [10:0] p;
        logic        pe;
        logic        fe;
    } frame_t;

    frame_t expQ[$];

    // Model: expected frame fields from what is put on the line.
    task automatic pushExp(input logic [7:0] d, input logic par, input logic stopBit);
        frame_t f;
        f.d  = d;
        f.p  = {stopBit, par, d, 1'b1};
        f.pe = (($countones({d, par}) % 2) != 0);
        f.fe = (stopBit == 1'b0);
        expQ.push_back(f);
    endtask

    task automatic driveBit(input logic b, input bit glitch);
        for (int c = 0; c < CPB; c++) begin
            rx = (glitch && (c == 7)) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic par, input logic stopBit, input bit glitch);
        pushExp(d, par, stopBit);
        driveBit(1'b0, glitch);
        for (int i = 0; i < 8; i++) driveBit(d[i], glitch);
        driveBit(par, glitch);
        driveBit(stopBit, glitch);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Compare process: every presented frame against the model, held values every cycle.
    logic [7:0]  lastD = '0;
    logic [10:0] lastP = '0;
    logic        lastPe = 1'b0;
    logic        lastFe = 1'b0;
    logic        prevV = 1'b0;
    int          validSeen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            lastD = '0; lastP = '0; lastPe = 1'b0; lastFe = 1'b0; prevV = 1'b0;
        end else begin
            if (data_valid) begin
                frame_t f;
                validSeen++;
                check("dv_single_cycle", 32'(prevV), 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: got data_out=0x%0h expected no frame at %0t", data_out, $time);
                end else begin
                    f = expQ.pop_front();
                    lastD = f.d; lastP = f.p; lastPe = f.pe; lastFe = f.fe;
                end
            end
            check("model_data_out",   32'(data_out),   32'(lastD));
            check("model_packet_out", 32'(packet_out), 32'(lastP));
            check("model_parity_err", 32'(parity_err), 32'(lastPe));
            check("model_frame_err",  32'(frame_err),  32'(lastFe));
            prevV = data_valid;
        end
    end

    task automatic checkAllZero(input string tag);
        check({tag, "_data_out"},   32'(data_out),   32'd0);
        check({tag, "_packet_out"}, 32'(packet_out), 32'd0);
        check({tag, "_data_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
        check({tag, "_frame_err"},  32'(frame_err),  32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        logic [7:0] abortByte;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        #2 rst_n = 1'b1;
        idle(20);

        // Clean frame 0xA5
        sendFrame(8'hA5, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("a5_data_out",   32'(data_out),   32'h0A5);
        check("a5_packet_out", 32'(packet_out), 32'h54B);
        check("a5_parity_err", 32'(parity_err), 32'd0);
        check("a5_frame_err",  32'(frame_err),  32'd0);
        check("a5_busy_idle",  32'(busy),       32'd0);

        // Wrong parity on 0x07
        sendFrame(8'h07, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("x07_data_out",   32'(data_out),   32'h07);
        check("x07_parity_err", 32'(parity_err), 32'd1);
        check("x07_frame_err",  32'(frame_err),  32'd0);

        // Bad stop bit on 0x3C, line then held low
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("x3c_busy_low_line", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check("x3c_busy_before_release", 32'(busy), 32'd1);
        check("x3c_frame_err",  32'(frame_err),  32'd1);
        check("x3c_parity_err", 32'(parity_err), 32'd0);
        check("x3c_data_out",   32'(data_out),   32'h3C);
        idle(10);
        check("x3c_busy_released", 32'(busy), 32'd0);
        idle(20);

        // Short low pulse: false start
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_during", 32'(busy), 32'd1);
        idle(10);
        check("glitch_busy_after", 32'(busy), 32'd0);
        idle(20);

        // Reset during data bit 4 of 0x5A
        abortByte = 8'h5A;
        driveBit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) driveBit(abortByte[i], 1'b0);
        rx = abortByte[4];
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("midreset");
        #2 rst_n = 1'b1;
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("midreset_no_frame_busy", 32'(busy), 32'd0);

        sendFrame(8'h5A, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("x5a_data_out",   32'(data_out),   32'h5A);
        check("x5a_parity_err", 32'(parity_err), 32'd0);
        check("x5a_frame_err",  32'(frame_err),  32'd0);

        // Back-to-back 0x00 then 0xFF, glitched when majority sampling is built in
        sendFrame(8'h00, 1'b0, 1'b1, GLITCH);
        sendFrame(8'hFF, 1'b0, 1'b1, GLITCH);
        idle(20);
        check("xff_data_out",   32'(data_out),   32'hFF);
        check("xff_packet_out", 32'(packet_out), 32'h5FF);
        check("xff_parity_err", 32'(parity_err), 32'd0);

        check("total_valids",   32'(validSeen),   32'd6);
        check("model_queue_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
